// File: rtl/nios_system_nios2_group_5_oci_dtrace_packer.sv
// Data-trace packer: packs 1..3-unit trace tokens LSB-first into a 30-bit word
// and hands each word downstream on a valid/ready handshake with flush support.
module nios_system_nios2_group_5_oci_dtrace_packer #(
  parameter int UNIT_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    trace_on,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_len,
  input  logic [3*UNIT_W-1:0]     in_data,
  input  logic                    flush,
  output logic                    dct_valid,
  input  logic                    dct_ready,
  output logic [UNIT_W*SLOTS-1:0] dct_buffer,
  output logic [CNT_W-1:0]        dct_count,
  output logic                    flush_done
);

  localparam int BUF_W = UNIT_W * SLOTS;
  localparam int TOK_W = 3 * UNIT_W;

  typedef enum logic [0:0] {S_FILL = 1'b0, S_EMIT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [TOK_W-1:0]   pend_data_q, pend_data_d;
  logic [1:0]         pend_len_q, pend_len_d;
  logic [BUF_W-1:0]   out_buf_q, out_buf_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               flush_latch_q, flush_latch_d;
  logic               flush_pend_q, flush_pend_d;
  logic               flush_done_q, flush_done_d;

  logic               ready_s;
  logic               tok_acc_s;
  logic               flush_req_s;
  logic [TOK_W-1:0]   mask_s;
  logic [TOK_W-1:0]   tok_s;
  logic [BUF_W-1:0]   ins_s;
  logic [CNT_W:0]     sum_s;
  logic [BUF_W-1:0]   acc_m_s;
  logic [CNT_W-1:0]   cnt_m_s;

  // Bits above the token length are don't-care, so they are masked before insertion.
  assign mask_s      = ~({TOK_W{1'b1}} << (UNIT_W * int'(in_len)));
  assign tok_s       = in_data & mask_s;
  assign ins_s       = BUF_W'(tok_s) << (UNIT_W * int'(acc_cnt_q));
  assign sum_s       = {1'b0, acc_cnt_q} + (CNT_W+1)'(in_len);
  assign tok_acc_s   = in_valid & ready_s & (in_len != 2'd0);
  assign flush_req_s = flush | flush_latch_q;
  assign acc_m_s     = tok_acc_s ? (acc_q | ins_s) : acc_q;
  assign cnt_m_s     = tok_acc_s ? sum_s[CNT_W-1:0] : acc_cnt_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_FILL;
      acc_q         <= '0;
      acc_cnt_q     <= '0;
      pend_data_q   <= '0;
      pend_len_q    <= 2'd0;
      out_buf_q     <= '0;
      out_cnt_q     <= '0;
      flush_latch_q <= 1'b0;
      flush_pend_q  <= 1'b0;
      flush_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      acc_cnt_q     <= acc_cnt_d;
      pend_data_q   <= pend_data_d;
      pend_len_q    <= pend_len_d;
      out_buf_q     <= out_buf_d;
      out_cnt_q     <= out_cnt_d;
      flush_latch_q <= flush_latch_d;
      flush_pend_q  <= flush_pend_d;
      flush_done_q  <= flush_done_d;
    end
  end

  // Next-state and accumulator update.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    acc_cnt_d     = acc_cnt_q;
    pend_data_d   = pend_data_q;
    pend_len_d    = pend_len_q;
    out_buf_d     = out_buf_q;
    out_cnt_d     = out_cnt_q;
    flush_latch_d = flush_latch_q;
    flush_pend_d  = flush_pend_q;
    flush_done_d  = 1'b0;
    case (state_q)
      S_FILL: begin
        if (tok_acc_s && (sum_s > (CNT_W+1)'(SLOTS))) begin
          // Tokens never split: ship the current word, park the token.
          out_buf_d     = acc_q;
          out_cnt_d     = acc_cnt_q;
          pend_data_d   = tok_s;
          pend_len_d    = in_len;
          acc_d         = '0;
          acc_cnt_d     = '0;
          flush_pend_d  = flush_req_s;
          flush_latch_d = 1'b0;
          state_d       = S_EMIT;
        end else if (tok_acc_s && (sum_s == (CNT_W+1)'(SLOTS))) begin
          out_buf_d     = acc_q | ins_s;
          out_cnt_d     = CNT_W'(SLOTS);
          acc_d         = '0;
          acc_cnt_d     = '0;
          flush_pend_d  = flush_req_s;
          flush_latch_d = 1'b0;
          state_d       = S_EMIT;
        end else if (flush_req_s) begin
          flush_latch_d = 1'b0;
          if (cnt_m_s != '0) begin
            out_buf_d    = acc_m_s;
            out_cnt_d    = cnt_m_s;
            acc_d        = '0;
            acc_cnt_d    = '0;
            flush_pend_d = 1'b1;
            state_d      = S_EMIT;
          end else begin
            flush_done_d = 1'b1;
          end
        end else begin
          acc_d     = acc_m_s;
          acc_cnt_d = cnt_m_s;
        end
      end
      S_EMIT: begin
        if (flush) begin
          flush_latch_d = 1'b1;
        end else begin
          flush_latch_d = flush_latch_q;
        end
        if (dct_ready) begin
          state_d      = S_FILL;
          acc_d        = BUF_W'(pend_data_q);
          acc_cnt_d    = CNT_W'(pend_len_q);
          pend_data_d  = '0;
          pend_len_d   = 2'd0;
          flush_pend_d = 1'b0;
          // A parked token under flush becomes a second word before flush_done.
          if (flush_pend_q && (pend_len_q == 2'd0)) begin
            flush_done_d = 1'b1;
          end else if (flush_pend_q) begin
            flush_latch_d = 1'b1;
          end else begin
            flush_done_d = 1'b0;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // Handshake outputs.
  always_comb begin
    ready_s   = 1'b0;
    dct_valid = 1'b0;
    if (state_q == S_FILL) begin
      ready_s = trace_on & reset_n;
    end else begin
      dct_valid = 1'b1;
    end
  end

  assign in_ready   = ready_s;
  assign dct_buffer = out_buf_q;
  assign dct_count  = out_cnt_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_nios_system_nios2_group_5_oci_dtrace_packer.sv
// Directed bench for the data-trace packer with hand-computed expected words.
module tb_nios_system_nios2_group_5_oci_dtrace_packer;

  logic        clk;
  logic        reset_n;
  logic        trace_on;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_len;
  logic [5:0]  in_data;
  logic        flush;
  logic        dct_valid;
  logic        dct_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        flush_done;

  int total = 0;
  int bad   = 0;

  nios_system_nios2_group_5_oci_dtrace_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trace_on   (trace_on),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_len     (in_len),
    .in_data    (in_data),
    .flush      (flush),
    .dct_valid  (dct_valid),
    .dct_ready  (dct_ready),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .flush_done (flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one token for one cycle (called at a negedge, returns at the next).
  task automatic tok(input logic [1:0] len, input logic [5:0] data, input logic fl);
    in_valid = 1'b1;
    in_len   = len;
    in_data  = data;
    flush    = fl;
    @(negedge clk);
    in_valid = 1'b0;
    in_len   = 2'd0;
    in_data  = 6'd0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic accept();
    dct_ready = 1'b1;
    @(negedge clk);
    dct_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    trace_on  = 1'b1;
    in_valid  = 1'b0;
    in_len    = 2'd0;
    in_data   = 6'd0;
    flush     = 1'b0;
    dct_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(dct_valid), 32'd0);
    chk("rst_buffer", 32'(dct_buffer), 32'd0);
    chk("rst_count", 32'(dct_count), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 15 single-unit tokens fill exactly one word.
    for (int i = 0; i < 14; i++) tok(2'd1, 6'h01, 1'b0);
    chk("t1_valid_14", 32'(dct_valid), 32'd0);
    tok(2'd1, 6'h01, 1'b0);
    chk("t1_valid", 32'(dct_valid), 32'd1);
    chk("t1_count", 32'(dct_count), 32'd15);
    chk("t1_buffer", 32'(dct_buffer), 32'h15555555);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t1_hold_valid", 32'(dct_valid), 32'd1);
    chk("t1_hold_ready", 32'(in_ready), 32'd0);
    accept();
    chk("t1_post_valid", 32'(dct_valid), 32'd0);
    chk("t1_post_ready", 32'(in_ready), 32'd1);
    chk("t1_post_fd", 32'(flush_done), 32'd0);

    // Overflow: 13 units held, a 3-unit token does not fit.
    tok(2'd3, 6'h01, 1'b0);
    tok(2'd3, 6'h02, 1'b0);
    tok(2'd3, 6'h03, 1'b0);
    tok(2'd3, 6'h04, 1'b0);
    tok(2'd1, 6'h3E, 1'b0);
    chk("t2_pre_valid", 32'(dct_valid), 32'd0);
    tok(2'd3, 6'h2A, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", 32'(dct_valid), 32'd1);
      chk("t2_hold_count", 32'(dct_count), 32'd13);
      chk("t2_hold_buffer", 32'(dct_buffer), 32'h2103081);
      @(negedge clk);
    end
    accept();
    chk("t2_post_valid", 32'(dct_valid), 32'd0);
    do_flush();
    chk("t2_pend_valid", 32'(dct_valid), 32'd1);
    chk("t2_pend_count", 32'(dct_count), 32'd3);
    chk("t2_pend_buffer", 32'(dct_buffer), 32'h2A);
    accept();
    chk("t2_fd", 32'(flush_done), 32'd1);

    // Partial word via flush, then flush on empty.
    tok(2'd2, 6'h0A, 1'b0);
    tok(2'd2, 6'h05, 1'b0);
    do_flush();
    chk("t3_valid", 32'(dct_valid), 32'd1);
    chk("t3_count", 32'(dct_count), 32'd4);
    chk("t3_buffer", 32'(dct_buffer), 32'h5A);
    chk("t3_fd_early", 32'(flush_done), 32'd0);
    accept();
    chk("t3_fd", 32'(flush_done), 32'd1);
    chk("t3_post_valid", 32'(dct_valid), 32'd0);
    @(negedge clk);
    chk("t3_fd_clear", 32'(flush_done), 32'd0);
    do_flush();
    chk("t3_empty_fd", 32'(flush_done), 32'd1);
    chk("t3_empty_valid", 32'(dct_valid), 32'd0);
    @(negedge clk);
    chk("t3_empty_fd_clear", 32'(flush_done), 32'd0);

    // Overflow together with flush: two words, one flush_done.
    for (int i = 0; i < 4; i++) tok(2'd3, 6'h3F, 1'b0);
    tok(2'd1, 6'h01, 1'b0);
    tok(2'd3, 6'h15, 1'b1);
    chk("t4_w1_valid", 32'(dct_valid), 32'd1);
    chk("t4_w1_count", 32'(dct_count), 32'd13);
    chk("t4_w1_buffer", 32'(dct_buffer), 32'h1FFFFFF);
    dct_ready = 1'b1;
    @(negedge clk);
    chk("t4_bubble_valid", 32'(dct_valid), 32'd0);
    chk("t4_bubble_fd", 32'(flush_done), 32'd0);
    @(negedge clk);
    chk("t4_w2_valid", 32'(dct_valid), 32'd1);
    chk("t4_w2_count", 32'(dct_count), 32'd3);
    chk("t4_w2_buffer", 32'(dct_buffer), 32'h15);
    @(negedge clk);
    dct_ready = 1'b0;
    chk("t4_fd", 32'(flush_done), 32'd1);
    chk("t4_post_valid", 32'(dct_valid), 32'd0);
    @(negedge clk);
    chk("t4_fd_clear", 32'(flush_done), 32'd0);

    // Zero-length tokens and trace_on=0 leave the accumulator alone.
    tok(2'd1, 6'h01, 1'b0);
    tok(2'd0, 6'h3F, 1'b0);
    trace_on = 1'b0;
    #1;
    chk("t5_off_ready", 32'(in_ready), 32'd0);
    tok(2'd2, 6'h03, 1'b0);
    trace_on = 1'b1;
    do_flush();
    chk("t5_valid", 32'(dct_valid), 32'd1);
    chk("t5_count", 32'(dct_count), 32'd1);
    chk("t5_buffer", 32'(dct_buffer), 32'h1);
    accept();
    chk("t5_fd", 32'(flush_done), 32'd1);

    // Reset in the middle of EMIT discards everything.
    tok(2'd2, 6'h03, 1'b1);
    chk("t6_valid", 32'(dct_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(dct_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_count", 32'(dct_count), 32'd0);
    chk("t6_buffer", 32'(dct_buffer), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    do_flush();
    chk("t6_empty_fd", 32'(flush_done), 32'd1);
    chk("t6_empty_valid", 32'(dct_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
